// File: rtl/butterfly_sequencer.sv
// butterfly_sequencer: front-panel sequencer for y = a + w*b, z = a - w*b on one shared multiplier
module butterfly_sequencer #(
  parameter int WIDTH       = 8,
  parameter int FRAC        = 7,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic             btn,
  input  logic [WIDTH-1:0] sw_data,
  output logic [WIDTH-1:0] led,
  output logic [2:0]       sel,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int W1 = WIDTH + 1;
  localparam int W2 = WIDTH + 2;
  localparam int WP = 2 * WIDTH;
  localparam logic [1:0] S_LOAD = 2'd0, S_MUL = 2'd1, S_ADD = 2'd2, S_SHOW = 2'd3;
  localparam logic signed [W2-1:0] MAXV = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [W2-1:0] MINV = {3'b111, {(WIDTH-1){1'b0}}};
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_db, r_db_q;
  logic [1:0]             r_state, r_mcnt;
  logic [2:0]             r_sel;
  logic [WIDTH-1:0]       r_led;
  logic signed [WIDTH-1:0] r_op [6];
  logic signed [WIDTH-1:0] r_p [4];
  logic [WIDTH-1:0]       r_res [4];
  logic                   w_sync, w_diff, w_press;
  logic signed [WIDTH-1:0] w_x, w_y;
  logic signed [WP-1:0]   w_prod, w_sh;
  logic signed [W1-1:0]   w_tre, w_tim;
  logic [WIDTH-1:0]       w_ry, w_iy, w_rz, w_iz;
  logic [1:0]             w_nsel;

  function automatic logic [WIDTH-1:0] sat(input logic signed [W2-1:0] v);
    return v > MAXV ? MAXV[WIDTH-1:0] : v < MINV ? MINV[WIDTH-1:0] : v[WIDTH-1:0];
  endfunction

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign w_diff  = w_sync != r_db;
  assign w_press = r_db & ~r_db_q;
  // product order p0..p3 = ReW*ReB, ImW*ImB, ReW*ImB, ImW*ReB
  assign w_x     = r_mcnt[0] ? r_op[1] : r_op[0];
  assign w_y     = (r_mcnt[0] ^ r_mcnt[1]) ? r_op[3] : r_op[2];
  assign w_prod  = WP'(w_x) * WP'(w_y);
  assign w_sh    = w_prod >>> FRAC;
  assign w_tre   = W1'(r_p[0]) - W1'(r_p[1]);
  assign w_tim   = W1'(r_p[2]) + W1'(r_p[3]);
  assign w_ry    = sat(W2'(r_op[4]) + W2'(w_tre));
  assign w_iy    = sat(W2'(r_op[5]) + W2'(w_tim));
  assign w_rz    = sat(W2'(r_op[4]) - W2'(w_tre));
  assign w_iz    = sat(W2'(r_op[5]) - W2'(w_tim));
  assign w_nsel  = r_sel[1:0] + 2'd1;
  assign led     = r_led;
  assign sel     = r_sel;
  assign busy    = r_state == S_MUL || r_state == S_ADD;
  assign done    = r_state == S_SHOW;

  // synchronize the raw button and accept a new level only after it has been stable for DEBOUNCE cycles
  always_ff @(posedge fastclk or posedge reset)
    if (reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
      r_db_q <= r_db;
      r_cnt  <= (w_diff && r_cnt != CW'(DEBOUNCE - 1)) ? r_cnt + CW'(1) : '0;
      if (w_diff && r_cnt == CW'(DEBOUNCE - 1)) r_db <= w_sync;
    end

  // LOAD -> MUL (4 products) -> ADD -> SHOW -> LOAD; presses outside LOAD/SHOW are ignored
  always_ff @(posedge fastclk or posedge reset)
    if (reset) begin
      r_state <= S_LOAD;
      r_mcnt  <= '0;
      r_sel   <= '0;
      r_led   <= '0;
      for (int i = 0; i < 6; i++) r_op[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        r_p[i]   <= '0;
        r_res[i] <= '0;
      end
    end else
      case (r_state)
        S_LOAD:
          if (w_press) begin
            r_op[r_sel] <= sw_data;
            r_led       <= sw_data;
            r_sel       <= r_sel == 3'd5 ? 3'd0 : r_sel + 3'd1;
            r_mcnt      <= '0;
            if (r_sel == 3'd5) r_state <= S_MUL;
          end
        S_MUL: begin
          r_p[r_mcnt] <= w_sh[WIDTH-1:0];
          r_mcnt      <= r_mcnt + 2'd1;
          r_led       <= '0;
          if (r_mcnt == 2'd3) r_state <= S_ADD;
        end
        S_ADD: begin
          r_res[0] <= w_ry;
          r_res[1] <= w_iy;
          r_res[2] <= w_rz;
          r_res[3] <= w_iz;
          r_sel    <= '0;
          r_led    <= '0;
          r_state  <= S_SHOW;
        end
        default:
          if (w_press) begin
            r_sel <= r_sel[1:0] == 2'd3 ? 3'd0 : {1'b0, w_nsel};
            r_led <= r_sel[1:0] == 2'd3 ? '0 : r_res[w_nsel];
            if (r_sel[1:0] == 2'd3) r_state <= S_LOAD;
          end else
            r_led <= r_res[r_sel[1:0]];
      endcase
endmodule

// File: tb/tb_butterfly_sequencer.sv
// tb_butterfly_sequencer: directed vectors for the butterfly front-panel sequencer
module tb_butterfly_sequencer;
  logic       clk = 1'b0;
  logic       reset, btn;
  logic [7:0] sw_data, led;
  logic [2:0] sel;
  logic       busy, done;
  int         n_tests = 0, n_fail = 0;

  butterfly_sequencer dut (
    .fastclk(clk), .reset(reset), .btn(btn), .sw_data(sw_data),
    .led(led), .sel(sel), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [7:0] v);
    sw_data = v;
    btn = 1'b1;
    repeat (12) @(negedge clk);
    btn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] v, input logic [2:0] exp_sel);
    press(v);
    check("load_led", led, v);
    check("load_sel", sel, exp_sel);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("busy_rise", n < 30, 1);
  endtask

  task automatic show(input logic [7:0] e0, e1, e2, e3);
    check("show_done", done, 1);
    check("show_sel0", sel, 0);
    check("show_ry", led, e0);
    press(8'h00);
    check("show_sel1", sel, 1);
    check("show_iy", led, e1);
    press(8'h00);
    check("show_rz", led, e2);
    press(8'h00);
    check("show_sel3", sel, 3);
    check("show_iz", led, e3);
    press(8'h00);
    check("back_led", led, 0);
    check("back_sel", sel, 0);
    check("back_done", done, 0);
  endtask

  task automatic run(input logic [7:0] w_re, w_im, b_re, b_im, a_re, a_im,
                     input logic [7:0] e0, e1, e2, e3);
    load(w_re, 1);
    load(w_im, 2);
    load(b_re, 3);
    load(b_im, 4);
    load(a_re, 5);
    press(a_im);
    show(e0, e1, e2, e3);
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    btn = 1'b0;
    sw_data = 8'h00;
    repeat (10) @(negedge clk);
    check("rst_led", led, 0);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    // 15-cycle raw pulse: exactly one press
    sw_data = 8'h40;
    btn = 1'b1;
    repeat (15) @(negedge clk);
    btn = 1'b0;
    repeat (15) @(negedge clk);
    check("pulse_sel", sel, 1);
    check("pulse_led", led, 8'h40);
    // glitches shorter than the debounce window
    for (int g = 1; g <= 3; g++) begin
      sw_data = 8'hEE;
      btn = 1'b1;
      repeat (g) @(negedge clk);
      btn = 1'b0;
      repeat (12) @(negedge clk);
      check("glitch_sel", sel, 1);
      check("glitch_led", led, 8'h40);
    end
    load(8'hC0, 2);
    load(8'h0A, 3);
    load(8'h04, 4);
    load(8'h01, 5);
    // 6th press with cycle-exact busy window and output latency
    sw_data = 8'h08;
    btn = 1'b1;
    wait_busy();
    btn = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
      btn = ~btn;
      sw_data = 8'h77;
    end
    check("busy_cycles", cnt, 5);
    check("pre_led", led, 0);
    check("pre_done", done, 1);
    @(negedge clk);
    check("lat6_led", led, 8'h08);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      btn = ~btn;
    end
    btn = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_sel", sel, 0);
    show(8'h08, 8'h05, 8'hFA, 8'h0B);
    // saturation
    run(8'h40, 8'h00, 8'h64, 8'h00, 8'h64, 8'h00, 8'h7F, 8'h00, 8'h32, 8'h00);
    // reset after 3rd operand
    load(8'h11, 1);
    load(8'h22, 2);
    load(8'h33, 3);
    reset = 1'b1;
    #1;
    check("mid_rst_sel", sel, 0);
    check("mid_rst_led", led, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    // reset during MUL
    load(8'h11, 1);
    load(8'h22, 2);
    load(8'h33, 3);
    load(8'h44, 4);
    load(8'h55, 5);
    sw_data = 8'h66;
    btn = 1'b1;
    wait_busy();
    reset = 1'b1;
    #1;
    check("mul_rst_busy", busy, 0);
    check("mul_rst_sel", sel, 0);
    check("mul_rst_led", led, 0);
    check("mul_rst_done", done, 0);
    btn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("mul_rst_idle", busy, 0);
    run(8'h40, 8'hC0, 8'h0A, 8'h04, 8'h01, 8'h08, 8'h08, 8'h05, 8'hFA, 8'h0B);
    // negative truncation rounds toward minus infinity
    run(8'hC0, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h02, 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
